block_interleaver: RTL
======================

BLOCK_INTERLEAVER -- requirements
Module: block_interleaver

Interface
REQ-001 SHALL have parameter ROWS, default 8: matrix row count, range 2..64.
REQ-002 SHALL have parameter COLS, default 8: matrix column count, range 2..64.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port din  input  1: coded bit from the encoder.
REQ-006 SHALL have port din_valid  input  1: din is qualified this cycle.
REQ-007 SHALL have port din_ready  output  1: block accepts din this cycle.
REQ-008 SHALL have port mode  input  1: 0 = interleave, 1 = deinterleave.
REQ-009 SHALL have port dout  output  1: permuted bit to the modulator.
REQ-010 SHALL have port dout_valid  output  1: dout is qualified.
REQ-011 SHALL have port dout_ready  input  1: downstream consumes dout this cycle.

Function
REQ-012 SHALL hold two ping-pong banks of ROWS*COLS bits; one bank is written while the other is read.
REQ-013 SHALL give each bank one of four states: EMPTY, FILLING, FULL, DRAINING.
- EMPTY -> FILLING: first accepted write.
- FILLING -> FULL: ROWS*COLS-th write.
- FULL -> DRAINING: first accepted read.
- DRAINING -> EMPTY: ROWS*COLS-th read.
REQ-014 SHALL accept a write when din_valid && din_ready.
- din_ready = 1 while the write bank is EMPTY or FILLING, else 0.
REQ-015 SHALL latch mode into the write bank on its EMPTY -> FILLING transition; mode changes mid-block are ignored.
REQ-016 SHALL address each bank by (row, col) counters:
- Interleave writes row-major and reads column-major.
- Deinterleave writes column-major and reads row-major, using the bank's latched mode.
REQ-017 SHALL drive dout combinationally from the read bank at the current read address.
- dout_valid = 1 while the read bank is FULL or DRAINING.
REQ-018 SHALL hold dout and dout_valid stable while dout_valid && !dout_ready.
REQ-019 SHALL advance the read address only on dout_valid && dout_ready.
REQ-020 SHALL assert dout_valid in the cycle after the last bit of a block is written, provided the other bank is EMPTY.
REQ-021 SHALL toggle the write-bank pointer on the final write and the read-bank pointer on the final read.
- When both happen in the same cycle, both toggle, and din_ready and dout_valid stay 1 with no bubble.
REQ-022 SHALL wrap the row and col counters at ROWS-1 and COLS-1 respectively.
- Counter width is $clog2 of the respective dimension.
REQ-023 SHALL keep a sustained 1 bit/cycle throughput when din_valid = 1 and dout_ready = 1 continuously.

Reset
REQ-024 SHALL, on rst low, immediately and asynchronously apply the reset state:
- Both banks EMPTY; all counters and both bank pointers 0; latched modes 0.
- din_ready = 1 after release; dout_valid = 0; dout = 0.
REQ-025 SHALL discard partial and undrained blocks on reset mid-operation; bank contents need not be cleared.

Configuration
REQ-026 SHALL, with INTERLEAVER_DEINT_EN defined, honour mode as in REQ-015/016.
REQ-027 SHALL, without INTERLEAVER_DEINT_EN, ignore mode and always interleave, with no column-major write path synthesised.

Structure
REQ-028 SHALL take the following from package interleaver_pkg:
- bank-state enum (EMPTY, FILLING, FULL, DRAINING);
- mode constants MODE_INTLV = 0 and MODE_DEINTLV = 1.
REQ-029 SHALL instantiate sub-module intlv_addr_gen twice, once for write and once for read.
- Inputs: clk, rst, step, mode.
- Outputs: row, col, last.

Verification
REQ-030 SHALL cover: ROWS=2, COLS=3, mode=0, din 1,1,0,1,0,0 -> dout 1,1,1,0,0,0, first dout_valid 1 cycle after the 6th write.
REQ-031 SHALL cover: ROWS=2, COLS=3, mode=1, din 1,1,1,0,0,0 -> dout 1,1,0,1,0,0.
REQ-032 SHALL cover: ROWS=8, COLS=8, dout_ready = 0 during 130 valid inputs -> din_ready falls after exactly 128 accepts, and dout holds the same bit throughout.
REQ-033 SHALL cover: continuous valid/ready, 4 blocks of 64 random bits -> each dout block is the transposed permutation, with zero bubbles at block boundaries.
REQ-034 SHALL cover: rst pulsed low after 10 writes -> dout_valid = 0 and din_ready = 1; the next 64 writes form a clean block.
REQ-035 SHALL cover: mode toggled after the 3rd write of a block -> that block uses its start mode, and the next block uses the new mode.

Source files
------------

// File: rtl/interleaver_pkg.sv
// ============================================================================
// interleaver_pkg : shared bank-state encoding and mode constants
// Rev 1.0
// ============================================================================
`default_nettype none

package interleaver_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    localparam logic MODE_INTLV   = 1'b0;
    localparam logic MODE_DEINTLV = 1'b1;

endpackage

`default_nettype wire

// File: rtl/intlv_addr_gen.sv
// ============================================================================
// intlv_addr_gen : wrapping (row, col) counter, row-major or column-major step
// Rev 1.0
// ============================================================================
`default_nettype none

module intlv_addr_gen
    import interleaver_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      step,
    input  logic                      mode,
    output logic [$clog2(ROWS)-1:0]   row,
    output logic [$clog2(COLS)-1:0]   col,
    output logic                      last
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic row_end;
    logic col_end;

    assign row_end = (row == ROW_MAX);
    assign col_end = (col == COL_MAX);
    // Both traversal orders finish on the bottom-right cell.
    assign last    = row_end && col_end;

    // mode == MODE_INTLV walks row-major (col fastest); otherwise column-major.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (mode == MODE_INTLV) begin
                col <= col_end ? '0 : col + 1'b1;
                if (col_end)
                    row <= row_end ? '0 : row + 1'b1;
            end else begin
                row <= row_end ? '0 : row + 1'b1;
                if (row_end)
                    col <= col_end ? '0 : col + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/block_interleaver.sv
// ============================================================================
// block_interleaver : ping-pong ROWSxCOLS bit block (de)interleaver
// Deinterleave support is built only with INTERLEAVER_DEINT_EN defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module block_interleaver
    import interleaver_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic din_valid,
    output logic din_ready,
    input  logic mode,
    output logic dout,
    output logic dout_valid,
    input  logic dout_ready
);

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = $clog2(DEPTH);

    bank_state_t              bank_state      [2];
    bank_state_t              bank_state_next [2];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [DEPTH-1:0]         mem [2];

    logic                     wr_mode;
    logic                     rd_mode;
    logic                     rd_order;
    logic                     wr_en;
    logic                     rd_en;
    logic [$clog2(ROWS)-1:0]  wr_row;
    logic [$clog2(COLS)-1:0]  wr_col;
    logic [$clog2(ROWS)-1:0]  rd_row;
    logic [$clog2(COLS)-1:0]  rd_col;
    logic                     wr_last;
    logic                     rd_last;
    logic [AW-1:0]            wr_addr;
    logic [AW-1:0]            rd_addr;

    assign din_ready  = (bank_state[wr_ptr] == EMPTY) || (bank_state[wr_ptr] == FILLING);
    assign dout_valid = (bank_state[rd_ptr] == FULL)  || (bank_state[rd_ptr] == DRAINING);
    assign wr_en      = din_valid && din_ready;
    assign rd_en      = dout_valid && dout_ready;

`ifdef INTERLEAVER_DEINT_EN
    logic bank_mode [2];

    // The first write of a block still sees the live mode; later ones use the latch.
    assign wr_mode = (bank_state[wr_ptr] == EMPTY) ? mode : bank_mode[wr_ptr];
    assign rd_mode = bank_mode[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_mode[0] <= MODE_INTLV;
            bank_mode[1] <= MODE_INTLV;
        end else if (wr_en && (bank_state[wr_ptr] == EMPTY)) begin
            bank_mode[wr_ptr] <= mode;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign wr_mode     = MODE_INTLV;
    assign rd_mode     = MODE_INTLV;
`endif

    // Reads traverse in the opposite order to the block's write order.
    assign rd_order = (rd_mode == MODE_DEINTLV) ? 1'b0 : 1'b1;

    intlv_addr_gen #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_wr_addr (
        .clk  (clk),
        .rst  (rst),
        .step (wr_en),
        .mode (wr_mode),
        .row  (wr_row),
        .col  (wr_col),
        .last (wr_last)
    );

    intlv_addr_gen #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_rd_addr (
        .clk  (clk),
        .rst  (rst),
        .step (rd_en),
        .mode (rd_order),
        .row  (rd_row),
        .col  (rd_col),
        .last (rd_last)
    );

    assign wr_addr = AW'(32'(wr_row) * COLS + 32'(wr_col));
    assign rd_addr = AW'(32'(rd_row) * COLS + 32'(rd_col));
    assign dout    = dout_valid ? mem[rd_ptr][rd_addr] : 1'b0;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr][wr_addr] <= din;
    end

    // Write and read never target the same bank: their qualifying states are disjoint.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_state_next[b] = bank_state[b];
            if (wr_en && (wr_ptr == 1'(b))) begin
                if (wr_last)
                    bank_state_next[b] = FULL;
                else if (bank_state[b] == EMPTY)
                    bank_state_next[b] = FILLING;
            end
            if (rd_en && (rd_ptr == 1'(b))) begin
                if (rd_last)
                    bank_state_next[b] = EMPTY;
                else if (bank_state[b] == FULL)
                    bank_state_next[b] = DRAINING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
        end else begin
            bank_state[0] <= bank_state_next[0];
            bank_state[1] <= bank_state_next[1];
            wr_ptr        <= wr_ptr ^ (wr_en && wr_last);
            rd_ptr        <= rd_ptr ^ (rd_en && rd_last);
        end
    end

endmodule

`default_nettype wire
